// File: rtl/m24c16_seq_pkg.sv
// Shared types and constants for the M24C16 transaction sequencer.
// Holds FSM states, status codes, byte-engine opcodes and the command bundle.
package m24c16_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DEVSEL_W = 4'd1,
    S_ADDR     = 4'd2,
    S_WDATA    = 4'd3,
    S_RSTART   = 4'd4,
    S_RDATA    = 4'd5,
    S_POLL     = 4'd6,
    S_ABORT    = 4'd7,
    S_FIN      = 4'd8
  } state_t;

  localparam logic [1:0] ERR_OK           = 2'd0;
  localparam logic [1:0] ERR_NACK         = 2'd1;
  localparam logic [1:0] ERR_POLL_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BAD_REQ      = 2'd3;

  localparam logic OP_BYTE      = 1'b0;
  localparam logic OP_STOP_ONLY = 1'b1;

  localparam logic [3:0] DEV_TYPE = 4'b1010;
  localparam logic [4:0] MAX_LEN  = 5'd16;

  typedef struct packed {
    logic       op;
    logic [7:0] data;
    logic       read;
    logic       start;
    logic       ack;
    logic       stop;
  } eng_cmd_t;

  function automatic eng_cmd_t mk_cmd(input logic op, input logic [7:0] data, input logic read,
                                      input logic start, input logic ack, input logic stop);
    eng_cmd_t c;
    c.op    = op;
    c.data  = data;
    c.read  = read;
    c.start = start;
    c.ack   = ack;
    c.stop  = stop;
    return c;
  endfunction

  function automatic logic [7:0] dev_byte(input logic [2:0] blk, input logic rw);
    return {DEV_TYPE, blk, rw};
  endfunction

endpackage

// File: rtl/m24c16_seq.sv
// M24C16 EEPROM transaction sequencer: turns read/write requests into a stream
// of byte-engine commands, including ACK polling after writes and NACK recovery.
module m24c16_seq
  import m24c16_seq_pkg::*;
#(
  parameter int POLL_MAX  = 255,
  parameter int PAGE_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_block,
  input  logic [7:0] req_addr,
  input  logic [4:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic [1:0] err,
  output logic       busy,
  output logic       eng_go,
  output logic       eng_op,
  output logic [7:0] eng_byte,
  output logic       eng_read,
  output logic       eng_start,
  output logic       eng_ack,
  output logic       eng_stop,
  input  logic       eng_done,
  input  logic       eng_nack,
  input  logic [7:0] eng_rdata
);

  localparam logic [8:0] POLL_LIM  = 9'(POLL_MAX);
  localparam logic [9:0] PAGE_W    = 10'(PAGE_SIZE);
  localparam logic [9:0] PAGE_MASK = 10'(PAGE_SIZE - 1);

  state_t     state_q, state_d;
  logic       issued_q, issued_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       write_q, write_d;
  logic [2:0] block_q, block_d;
  logic [7:0] addr_q, addr_d;
  logic [4:0] len_q, len_d;
  eng_cmd_t   cmd_q, cmd_d;
  logic       go_q, go_d;
  logic       wr_ready_q, wr_ready_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       done_q, done_d;
  logic [1:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       req_ready_q, req_ready_d;

  logic       fin_s;
  logic [1:0] fin_err_s;
  logic [9:0] page_end_s;
  logic       bad_req_s;
  logic       last_byte_s;
  logic [4:0] cnt_next_s;

  assign page_end_s  = (10'(req_addr) & PAGE_MASK) + 10'(req_len);
  assign bad_req_s   = (req_len == 5'd0) || (req_len > MAX_LEN) ||
                       (req_write && (page_end_s > PAGE_W));
  assign last_byte_s = (byte_cnt_q == (len_q - 5'd1));
  assign cnt_next_s  = byte_cnt_q + 5'd1;

  // Each command state issues once (issued_q), then waits for the engine's reply.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    write_d     = write_q;
    block_d     = block_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    go_d        = 1'b0;
    wr_ready_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = ERR_OK;
    fin_s       = 1'b0;
    fin_err_s   = ERR_OK;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          block_d    = req_block;
          addr_d     = req_addr;
          len_d      = req_len;
          byte_cnt_d = 5'd0;
          poll_cnt_d = 8'd0;
          issued_d   = 1'b0;
          if (bad_req_s) begin
            fin_s     = 1'b1;
            fin_err_s = ERR_BAD_REQ;
          end else begin
            state_d = S_DEVSEL_W;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DEVSEL_W: begin
        if (!issued_q) begin
          cmd_d    = mk_cmd(OP_BYTE, dev_byte(block_q, 1'b0), 1'b0, 1'b1, 1'b1, 1'b0);
          go_d     = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          issued_d = 1'b0;
          state_d  = eng_nack ? S_ABORT : S_ADDR;
        end else begin
          state_d = S_DEVSEL_W;
        end
      end
      S_ADDR: begin
        if (!issued_q) begin
          cmd_d    = mk_cmd(OP_BYTE, addr_q, 1'b0, 1'b0, 1'b1, 1'b0);
          go_d     = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          issued_d = 1'b0;
          state_d  = eng_nack ? S_ABORT : (write_q ? S_WDATA : S_RSTART);
        end else begin
          state_d = S_ADDR;
        end
      end
      S_WDATA: begin
        // The byte is captured on the issuing edge, so wr_ready rides with eng_go.
        if (!issued_q) begin
          if (wr_valid) begin
            cmd_d      = mk_cmd(OP_BYTE, wr_data, 1'b0, 1'b0, 1'b1, last_byte_s);
            go_d       = 1'b1;
            wr_ready_d = 1'b1;
            issued_d   = 1'b1;
          end else begin
            issued_d = 1'b0;
          end
        end else if (eng_done) begin
          issued_d = 1'b0;
          if (eng_nack) begin
            state_d = S_ABORT;
          end else begin
            byte_cnt_d = cnt_next_s;
            state_d    = last_byte_s ? S_POLL : S_WDATA;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RSTART: begin
        if (!issued_q) begin
          cmd_d    = mk_cmd(OP_BYTE, dev_byte(block_q, 1'b1), 1'b0, 1'b1, 1'b1, 1'b0);
          go_d     = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          issued_d = 1'b0;
          state_d  = eng_nack ? S_ABORT : S_RDATA;
        end else begin
          state_d = S_RSTART;
        end
      end
      S_RDATA: begin
        if (!issued_q) begin
          cmd_d    = mk_cmd(OP_BYTE, 8'h00, 1'b1, 1'b0, !last_byte_s, last_byte_s);
          go_d     = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          issued_d   = 1'b0;
          rd_data_d  = eng_rdata;
          rd_valid_d = 1'b1;
          byte_cnt_d = cnt_next_s;
          if (last_byte_s) begin
            fin_s     = 1'b1;
            fin_err_s = ERR_OK;
          end else begin
            state_d = S_RDATA;
          end
        end else begin
          state_d = S_RDATA;
        end
      end
      S_POLL: begin
        if (!issued_q) begin
          cmd_d    = mk_cmd(OP_BYTE, dev_byte(block_q, 1'b0), 1'b0, 1'b1, 1'b1, 1'b1);
          go_d     = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          issued_d = 1'b0;
          if (!eng_nack) begin
            fin_s     = 1'b1;
            fin_err_s = ERR_OK;
          end else if (({1'b0, poll_cnt_q} + 9'd1) >= POLL_LIM) begin
            poll_cnt_d = poll_cnt_q + 8'd1;
            fin_s      = 1'b1;
            fin_err_s  = ERR_POLL_TIMEOUT;
          end else begin
            poll_cnt_d = poll_cnt_q + 8'd1;
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_ABORT: begin
        if (!issued_q) begin
          cmd_d    = mk_cmd(OP_STOP_ONLY, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
          go_d     = 1'b1;
          issued_d = 1'b1;
        end else if (eng_done) begin
          fin_s     = 1'b1;
          fin_err_s = ERR_NACK;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin_s) begin
      state_d  = S_FIN;
      issued_d = 1'b0;
      done_d   = 1'b1;
      err_d    = fin_err_s;
    end else begin
      done_d = 1'b0;
    end

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issued_q    <= 1'b0;
      byte_cnt_q  <= 5'd0;
      poll_cnt_q  <= 8'd0;
      write_q     <= 1'b0;
      block_q     <= 3'd0;
      addr_q      <= 8'd0;
      len_q       <= 5'd0;
      cmd_q       <= '0;
      go_q        <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'd0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      write_q     <= write_d;
      block_q     <= block_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      go_q        <= go_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign eng_go    = go_q;
  assign eng_op    = cmd_q.op;
  assign eng_byte  = cmd_q.data;
  assign eng_read  = cmd_q.read;
  assign eng_start = cmd_q.start;
  assign eng_ack   = cmd_q.ack;
  assign eng_stop  = cmd_q.stop;

endmodule
